// File: rtl/seg7_scan_pkg.sv
// Shared constants for the 7-segment scan driver: digit count default,
// hex-to-segment table, scan state encoding. Segment values are active-high.
package seg7_scan_pkg;

    localparam int DEF_NUM_DIGITS = 8;

    // Segment bit order is {g,f,e,d,c,b,a}; element n is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic       AN_OFF  = 1'b0;
    localparam logic       DP_OFF  = 1'b0;

    typedef enum logic {
        ST_UNPRIMED,
        ST_SCAN
    } scan_state_e;

    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Control/display bundle between a value source and the seg7_scan driver.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output tick, value, dp_mask, blank_lz,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  tick, value, dp_mask, blank_lz,
        output an, seg, dp, frame_start
    );

endinterface

// File: rtl/seg7_scan_hex_to_seg7.sv
// Combinational 4-bit nibble to active-high 7-segment pattern.
module hex_to_seg7
    import seg7_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = hex_seg(i_nibble);
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed hex display driver: steps one digit per scan tick and shows a
// per-frame snapshot of the input value, with leading-zero blanking and DP mask.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    seg7_scan_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_RST  = {NUM_DIGITS{AN_OFF}} ^ AN_POL;
    localparam logic [6:0]            SEG_RST = SEG_OFF ^ SEG_POL;
    localparam logic                  DP_RST  = DP_OFF ^ ACTIVE_LOW;

    scan_state_e        r_state;
    scan_state_e        w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [VAL_W-1:0]   r_shadow;
    logic [VAL_W-1:0]   w_shadow_nxt;
    logic               w_reload;

    logic [IDX_W+1:0]   w_bitpos;
    logic [3:0]         w_nibble;
    logic [VAL_W-1:0]   w_upper;
    logic               w_blank;
    logic [6:0]         w_seg_hex;
    logic [6:0]         w_seg_hi;
    logic [NUM_DIGITS-1:0] w_an_hi;
    logic               w_dp_hi;

    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_UNPRIMED;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    // A frame (re)starts on the first tick after reset or after the last digit.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_shadow_nxt = r_shadow;
        w_reload     = 1'b0;
        if (bus.tick) begin
            if (r_state == ST_UNPRIMED || r_idx == LAST_IDX) begin
                w_reload     = 1'b1;
                w_idx_nxt    = '0;
                w_shadow_nxt = bus.value;
                w_state_nxt  = ST_SCAN;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end
    end

    // Outputs are decoded from the post-edge index/snapshot so they land with it.
    always_comb begin
        w_bitpos = {w_idx_nxt, 2'b00};
        w_nibble = w_shadow_nxt[w_bitpos +: 4];
        w_upper  = w_shadow_nxt >> w_bitpos;
        w_blank  = bus.blank_lz && (w_idx_nxt != '0) && (w_upper == '0);
        w_seg_hi = w_blank ? SEG_OFF : w_seg_hex;
        w_an_hi  = NUM_DIGITS'(1) << w_idx_nxt;
        w_dp_hi  = bus.dp_mask[w_idx_nxt];
    end

    hex_to_seg7 u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_hex)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an          <= AN_RST;
            r_seg         <= SEG_RST;
            r_dp          <= DP_RST;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_reload;
            if (bus.tick) begin
                r_an  <= w_an_hi ^ AN_POL;
                r_seg <= w_seg_hi ^ SEG_POL;
                r_dp  <= w_dp_hi ^ ACTIVE_LOW;
            end
        end
    end

    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed scenarios plus randomized traffic
// compared against a frame/digit reference model.
module tb_seg7_scan;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_if #(.NUM_DIGITS(8)) bus();

    seg7_scan #(.NUM_DIGITS(8), .ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: which digit is shown, the frame snapshot, and what is lit.
    int          m_idx    = 0;
    logic [31:0] m_shadow = '0;
    bit          m_primed = 0;
    bit          m_lit    = 0;
    bit          m_fs     = 0;
    bit          m_dp_on  = 0;
    logic [6:0]  m_seg_hi = '0;

    function automatic logic [7:0] exp_an();
        return m_lit ? ~(8'(1) << m_idx) : 8'hFF;
    endfunction

    function automatic logic [6:0] exp_seg();
        return m_lit ? ~m_seg_hi : 7'h7F;
    endfunction

    function automatic logic exp_dp();
        return m_lit ? ~m_dp_on : 1'b1;
    endfunction

    task automatic clk_cycle();
        logic [3:0] nib;
        if (reset) begin
            m_idx = 0; m_shadow = '0; m_primed = 0; m_fs = 0; m_lit = 0;
        end else if (bus.tick) begin
            if (!m_primed || m_idx == 7) begin
                m_idx = 0; m_shadow = bus.value; m_primed = 1; m_fs = 1;
            end else begin
                m_idx++; m_fs = 0;
            end
            m_lit = 1;
            nib = m_shadow[4*m_idx +: 4];
            if (bus.blank_lz && m_idx > 0 && (m_shadow >> (4*m_idx)) == 0)
                m_seg_hi = 7'h00;
            else
                m_seg_hi = hex7[nib];
            m_dp_on = bus.dp_mask[m_idx];
        end else begin
            m_fs = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        clk_cycle();
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.tick = 1'b1;
        bus.value = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            clk_cycle();
            n_checks++;
            if (bus.an !== 8'hFF) begin n_errors++; $display("FAIL reset_an cyc=%0d got=%h exp=FF", k, bus.an); end
            n_checks++;
            if (bus.seg !== 7'h7F) begin n_errors++; $display("FAIL reset_seg cyc=%0d got=%h exp=7F", k, bus.seg); end
            n_checks++;
            if (bus.dp !== 1'b1) begin n_errors++; $display("FAIL reset_dp cyc=%0d got=%b exp=1", k, bus.dp); end
            n_checks++;
            if (bus.frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_fs cyc=%0d got=%b exp=0", k, bus.frame_start); end
        end
        reset = 1'b0;
        bus.tick = 1'b0;
        clk_cycle();
        n_checks++;
        if (bus.an !== 8'hFF) begin n_errors++; $display("FAIL idle_after_reset_an got=%h exp=FF", bus.an); end
    endtask

    task automatic test_walk();
        logic [7:0] an_exp [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        logic [6:0] seg_exp [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        bus.value = 32'h1234ABCD;
        for (int k = 0; k < 8; k++) begin
            tick_once();
            n_checks++;
            if (bus.an !== an_exp[k]) begin n_errors++; $display("FAIL walk_an d=%0d got=%h exp=%h", k, bus.an, an_exp[k]); end
            n_checks++;
            if (bus.seg !== seg_exp[k]) begin n_errors++; $display("FAIL walk_seg d=%0d got=%h exp=%h", k, bus.seg, seg_exp[k]); end
            n_checks++;
            if (bus.frame_start !== (k == 0)) begin n_errors++; $display("FAIL walk_fs d=%0d got=%b exp=%b", k, bus.frame_start, (k == 0)); end
            n_checks++;
            if (bus.dp !== 1'b1) begin n_errors++; $display("FAIL walk_dp d=%0d got=%b exp=1", k, bus.dp); end
            repeat (9) clk_cycle();
            n_checks++;
            if (bus.an !== an_exp[k] || bus.frame_start !== 1'b0) begin
                n_errors++; $display("FAIL walk_hold d=%0d an=%h fs=%b exp an=%h fs=0", k, bus.an, bus.frame_start, an_exp[k]);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [6:0] old_seg [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        bus.value = 32'h1234ABCD;
        repeat (3) tick_once();
        bus.value = 32'hFFFFFFFF;
        for (int k = 3; k < 8; k++) begin
            tick_once();
            n_checks++;
            if (bus.seg !== old_seg[k]) begin n_errors++; $display("FAIL snap_old d=%0d got=%h exp=%h", k, bus.seg, old_seg[k]); end
        end
        tick_once();
        n_checks++;
        if (bus.frame_start !== 1'b1) begin n_errors++; $display("FAIL snap_fs got=%b exp=1", bus.frame_start); end
        n_checks++;
        if (bus.seg !== 7'h0E) begin n_errors++; $display("FAIL snap_new_seg got=%h exp=0E", bus.seg); end
        n_checks++;
        if (bus.an !== 8'hFE) begin n_errors++; $display("FAIL snap_an got=%h exp=FE", bus.an); end
        repeat (7) tick_once();
    endtask

    task automatic test_blank();
        logic [6:0] exp_s;
        bus.blank_lz = 1'b1;
        bus.value = 32'h000000A0;
        for (int k = 0; k < 8; k++) begin
            tick_once();
            exp_s = (k == 0) ? 7'h40 : (k == 1) ? 7'h08 : 7'h7F;
            n_checks++;
            if (bus.seg !== exp_s) begin n_errors++; $display("FAIL blank_a0_seg d=%0d got=%h exp=%h", k, bus.seg, exp_s); end
            n_checks++;
            if (bus.an !== ~(8'(1) << k)) begin n_errors++; $display("FAIL blank_a0_an d=%0d got=%h exp=%h", k, bus.an, ~(8'(1) << k)); end
        end
        bus.value = 32'h0;
        for (int k = 0; k < 8; k++) begin
            tick_once();
            exp_s = (k == 0) ? 7'h40 : 7'h7F;
            n_checks++;
            if (bus.seg !== exp_s) begin n_errors++; $display("FAIL blank_zero_seg d=%0d got=%h exp=%h", k, bus.seg, exp_s); end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_dp_back_to_back();
        bus.value = $urandom;
        bus.dp_mask = 8'h04;
        bus.tick = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clk_cycle();
            n_checks++;
            if (bus.an !== ~(8'(1) << k)) begin n_errors++; $display("FAIL b2b_an step=%0d got=%h exp=%h", k, bus.an, ~(8'(1) << k)); end
            n_checks++;
            if (bus.dp !== (k != 2)) begin n_errors++; $display("FAIL dp_mask step=%0d got=%b exp=%b", k, bus.dp, (k != 2)); end
        end
        bus.tick = 1'b0;
        for (int k = 5; k < 8; k++) begin
            tick_once();
            n_checks++;
            if (bus.dp !== 1'b1) begin n_errors++; $display("FAIL dp_off d=%0d got=%b exp=1", k, bus.dp); end
        end
        bus.dp_mask = 8'h00;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus.value = 32'h89ABCDEF;
        repeat (6) tick_once();
        n_checks++;
        if (bus.an !== 8'hDF) begin n_errors++; $display("FAIL mid_pre_an got=%h exp=DF", bus.an); end
        reset = 1'b1;
        clk_cycle();
        reset = 1'b0;
        n_checks++;
        if (bus.an !== 8'hFF || bus.seg !== 7'h7F || bus.frame_start !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset an=%h seg=%h fs=%b exp an=FF seg=7F fs=0", bus.an, bus.seg, bus.frame_start);
        end
        v = $urandom;
        bus.value = v;
        clk_cycle();
        tick_once();
        n_checks++;
        if (bus.an !== 8'hFE || bus.frame_start !== 1'b1) begin
            n_errors++; $display("FAIL mid_restart an=%h fs=%b exp an=FE fs=1", bus.an, bus.frame_start);
        end
        n_checks++;
        if (bus.seg !== ~hex7[v[3:0]]) begin n_errors++; $display("FAIL mid_snapshot got=%h exp=%h", bus.seg, ~hex7[v[3:0]]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 59) == 0);
            bus.tick     = ($urandom_range(0, 2) == 0);
            bus.value    = $urandom >> $urandom_range(0, 31);
            bus.dp_mask  = 8'($urandom);
            bus.blank_lz = 1'($urandom);
            clk_cycle();
            n_checks++;
            if (bus.an !== exp_an()) begin n_errors++; $display("FAIL rand_an cyc=%0d got=%h exp=%h", c, bus.an, exp_an()); end
            n_checks++;
            if (bus.seg !== exp_seg()) begin n_errors++; $display("FAIL rand_seg cyc=%0d got=%h exp=%h", c, bus.seg, exp_seg()); end
            n_checks++;
            if (bus.dp !== exp_dp()) begin n_errors++; $display("FAIL rand_dp cyc=%0d got=%b exp=%b", c, bus.dp, exp_dp()); end
            n_checks++;
            if (bus.frame_start !== m_fs) begin n_errors++; $display("FAIL rand_fs cyc=%0d got=%b exp=%b", c, bus.frame_start, m_fs); end
        end
        reset = 1'b0;
        bus.tick = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick     = 1'b0;
        bus.value    = '0;
        bus.dp_mask  = '0;
        bus.blank_lz = 1'b0;
        test_reset();
        test_walk();
        test_snapshot();
        test_blank();
        test_dp_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
